// File: rtl/inst_loader.sv
// inst_loader: receives a program image over a byte stream (UART RX side)
// and writes it into instruction memory, then releases the core from reset.
// Stream format: 4-byte little-endian word count N, then N little-endian
// 32-bit words. Headers larger than the memory depth lock the block in error.
module inst_loader #(
   parameter int DATA_WIDTH          = 32,
   parameter int INST_MEM_ADDR_WIDTH = 10
) (
   input  logic                           i_clk,
   input  logic                           i_rst_n,
   input  logic                           i_rx_valid,
   input  logic [7:0]                     i_rx_data,
   output logic                           o_rx_ready,
   output logic                           o_we_inst,
   output logic [INST_MEM_ADDR_WIDTH-1:0] o_addr_inst,
   output logic [DATA_WIDTH-1:0]          o_wrdata_inst,
   output logic                           o_core_rst_n,
   output logic                           o_done,
   output logic                           o_err
);

   localparam logic [1:0] S_LEN  = 2'd0;
   localparam logic [1:0] S_DATA = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;
   localparam logic [1:0] S_ERR  = 2'd3;

   localparam logic [31:0] MEM_DEPTH = 32'd1 << INST_MEM_ADDR_WIDTH;

   logic [1:0]                     state_r;
   logic [1:0]                     byte_cnt_r;
   logic [23:0]                    hold_r;       // first three bytes of the word being assembled
   logic [31:0]                    len_r;        // word count N from the header
   logic [INST_MEM_ADDR_WIDTH-1:0] word_idx_r;
   logic                           ready_en_r;   // keeps ready low until the first edge after reset
   logic                           we_r;
   logic [INST_MEM_ADDR_WIDTH-1:0] addr_r;
   logic [DATA_WIDTH-1:0]          wrdata_r;
   logic                           core_rst_n_r;

   logic                           accept_s;
   logic                           in_load_s;
   logic [31:0]                    word_s;
   logic                           last_word_s;
   logic [23:0]                    hold_next_s;

   // Handshake qualification, current assembled word and next holding value.
   always_comb begin
      in_load_s   = (state_r == S_LEN) || (state_r == S_DATA);
      accept_s    = i_rx_valid && ready_en_r && in_load_s;
      word_s      = {i_rx_data, hold_r};
      last_word_s = (32'(word_idx_r) == (len_r - 32'd1));
      hold_next_s = hold_r;
      case (byte_cnt_r)
         2'd0:    hold_next_s[7:0]   = i_rx_data;
         2'd1:    hold_next_s[15:8]  = i_rx_data;
         2'd2:    hold_next_s[23:16] = i_rx_data;
         default: hold_next_s        = hold_r;
      endcase
   end

   // Loader FSM, byte assembly and registered memory-write outputs.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_r      <= S_LEN;
         byte_cnt_r   <= 2'd0;
         hold_r       <= 24'd0;
         len_r        <= 32'd0;
         word_idx_r   <= '0;
         ready_en_r   <= 1'b0;
         we_r         <= 1'b0;
         addr_r       <= '0;
         wrdata_r     <= '0;
         core_rst_n_r <= 1'b0;
      end else begin
         ready_en_r   <= 1'b1;
         we_r         <= 1'b0;
         core_rst_n_r <= (state_r == S_DONE);
         if (accept_s) begin
            case (state_r)
               S_LEN: begin
                  if (byte_cnt_r == 2'd3) begin
                     byte_cnt_r <= 2'd0;
                     len_r      <= word_s;
                     word_idx_r <= '0;
                     if (word_s == 32'd0) begin
                        state_r <= S_DONE;
                     end else if (word_s > MEM_DEPTH) begin
                        state_r <= S_ERR;
                     end else begin
                        state_r <= S_DATA;
                     end
                  end else begin
                     byte_cnt_r <= byte_cnt_r + 2'd1;
                     hold_r     <= hold_next_s;
                  end
               end
               S_DATA: begin
                  if (byte_cnt_r == 2'd3) begin
                     byte_cnt_r <= 2'd0;
                     we_r       <= 1'b1;
                     addr_r     <= word_idx_r;
                     wrdata_r   <= DATA_WIDTH'(word_s);
                     if (last_word_s) begin
                        // Done is raised together with the final write pulse.
                        state_r <= S_DONE;
                     end else begin
                        word_idx_r <= word_idx_r + INST_MEM_ADDR_WIDTH'(1);
                     end
                  end else begin
                     byte_cnt_r <= byte_cnt_r + 2'd1;
                     hold_r     <= hold_next_s;
                  end
               end
               default: begin
                  state_r <= state_r;
               end
            endcase
         end else begin
            state_r <= state_r;
         end
      end
   end

   assign o_rx_ready    = ready_en_r && in_load_s;
   assign o_we_inst     = we_r;
   assign o_addr_inst   = addr_r;
   assign o_wrdata_inst = wrdata_r;
   assign o_done        = (state_r == S_DONE);
   assign o_err         = (state_r == S_ERR);
   assign o_core_rst_n  = core_rst_n_r;

endmodule

// File: tb/tb_inst_loader.sv
// Directed testbench for inst_loader: byte-stream loads, boundary headers,
// valid gaps, mid-load reset and post-completion behaviour.
module tb_inst_loader;

   logic       i_clk = 1'b0;
   logic       i_rst_n = 1'b0;
   logic       i_rx_valid = 1'b0;
   logic [7:0] i_rx_data = 8'd0;
   logic       o_rx_ready, o_we_inst, o_core_rst_n, o_done, o_err;
   logic [9:0] o_addr_inst;
   logic [31:0] o_wrdata_inst;

   int n_cmp = 0;
   int n_bad = 0;

   logic [9:0]  wr_addr_q[$];
   logic [31:0] wr_data_q[$];

   inst_loader #(.DATA_WIDTH(32), .INST_MEM_ADDR_WIDTH(10)) dut (
      .i_clk(i_clk), .i_rst_n(i_rst_n), .i_rx_valid(i_rx_valid), .i_rx_data(i_rx_data),
      .o_rx_ready(o_rx_ready), .o_we_inst(o_we_inst), .o_addr_inst(o_addr_inst),
      .o_wrdata_inst(o_wrdata_inst), .o_core_rst_n(o_core_rst_n), .o_done(o_done), .o_err(o_err)
   );

   always #5 i_clk = ~i_clk;

   // Write monitor: records every memory write, sampled mid-cycle.
   always @(negedge i_clk) begin
      if (i_rst_n && o_we_inst) begin
         wr_addr_q.push_back(o_addr_inst);
         wr_data_q.push_back(o_wrdata_inst);
      end
   end

   task automatic send_byte(input logic [7:0] b);
      i_rx_valid = 1'b1;
      i_rx_data  = b;
      @(posedge i_clk); #1;
      i_rx_valid = 1'b0;
      i_rx_data  = 8'hxx;
   endtask

   task automatic send_word(input logic [31:0] w);
      for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8]);
   endtask

   task automatic do_reset();
      i_rx_valid = 1'b0;
      i_rst_n = 1'b0;
      @(posedge i_clk); #1;
      wr_addr_q.delete();
      wr_data_q.delete();
      i_rst_n = 1'b1;
      @(posedge i_clk); #1;
   endtask

   task automatic test_reset();
      i_rst_n = 1'b0;
      #17;
      n_cmp++; if (o_we_inst !== 1'b0) begin n_bad++; $display("FAIL reset_we: got %b want 0", o_we_inst); end
      n_cmp++; if (o_addr_inst !== 10'd0) begin n_bad++; $display("FAIL reset_addr: got %h want 0", o_addr_inst); end
      n_cmp++; if (o_wrdata_inst !== 32'd0) begin n_bad++; $display("FAIL reset_wrdata: got %h want 0", o_wrdata_inst); end
      n_cmp++; if ({o_done, o_err, o_core_rst_n} !== 3'b000) begin n_bad++; $display("FAIL reset_flags: got %b want 000", {o_done, o_err, o_core_rst_n}); end
      @(posedge i_clk); #1;
      i_rst_n = 1'b1;
      @(posedge i_clk); #1;
      n_cmp++; if (o_rx_ready !== 1'b1) begin n_bad++; $display("FAIL reset_ready: got %b want 1", o_rx_ready); end
   endtask

   task automatic test_basic_load();
      do_reset();
      send_word(32'd2);
      send_word(32'h00100513);
      send_word(32'h00200593);
      // Now in the cycle of the second write pulse.
      n_cmp++; if (o_we_inst !== 1'b1) begin n_bad++; $display("FAIL basic_we2: got %b want 1", o_we_inst); end
      n_cmp++; if (o_done !== 1'b1) begin n_bad++; $display("FAIL basic_done_with_write: got %b want 1", o_done); end
      n_cmp++; if (o_core_rst_n !== 1'b0) begin n_bad++; $display("FAIL basic_core_rst_early: got %b want 0", o_core_rst_n); end
      @(posedge i_clk); #1;
      n_cmp++; if (o_core_rst_n !== 1'b1) begin n_bad++; $display("FAIL basic_core_rst: got %b want 1", o_core_rst_n); end
      n_cmp++; if (o_we_inst !== 1'b0) begin n_bad++; $display("FAIL basic_we_pulse: got %b want 0", o_we_inst); end
      n_cmp++; if (wr_addr_q.size() !== 2) begin n_bad++; $display("FAIL basic_nwrites: got %0d want 2", wr_addr_q.size()); end
      else begin
         n_cmp++; if ({wr_addr_q[0], wr_data_q[0]} !== {10'd0, 32'h00100513}) begin n_bad++; $display("FAIL basic_w0: got %h/%h want 000/00100513", wr_addr_q[0], wr_data_q[0]); end
         n_cmp++; if ({wr_addr_q[1], wr_data_q[1]} !== {10'd1, 32'h00200593}) begin n_bad++; $display("FAIL basic_w1: got %h/%h want 001/00200593", wr_addr_q[1], wr_data_q[1]); end
      end
   endtask

   task automatic test_after_done();
      logic [9:0] a0;
      logic [31:0] d0;
      // Continues from a completed load.
      a0 = 10'd1;
      d0 = 32'h00200593;
      for (int i = 0; i < 5; i++) begin
         n_cmp++; if (o_rx_ready !== 1'b0) begin n_bad++; $display("FAIL done_ready: got %b want 0", o_rx_ready); end
         send_byte(8'h5A + 8'(i));
      end
      repeat (3) @(posedge i_clk); #1;
      n_cmp++; if (wr_addr_q.size() !== 2) begin n_bad++; $display("FAIL done_nwrites: got %0d want 2", wr_addr_q.size()); end
      n_cmp++; if ({o_addr_inst, o_wrdata_inst} !== {a0, d0}) begin n_bad++; $display("FAIL done_stable: got %h/%h want %h/%h", o_addr_inst, o_wrdata_inst, a0, d0); end
      n_cmp++; if ({o_done, o_err, o_core_rst_n, o_we_inst} !== 4'b1010) begin n_bad++; $display("FAIL done_flags: got %b want 1010", {o_done, o_err, o_core_rst_n, o_we_inst}); end
   endtask

   task automatic test_zero_len();
      do_reset();
      send_word(32'd0);
      n_cmp++; if ({o_done, o_core_rst_n} !== 2'b10) begin n_bad++; $display("FAIL zero_done: got %b want 10", {o_done, o_core_rst_n}); end
      @(posedge i_clk); #1;
      n_cmp++; if (o_core_rst_n !== 1'b1) begin n_bad++; $display("FAIL zero_core_rst: got %b want 1", o_core_rst_n); end
      n_cmp++; if (wr_addr_q.size() !== 0) begin n_bad++; $display("FAIL zero_nwrites: got %0d want 0", wr_addr_q.size()); end
   endtask

   task automatic test_len_error();
      do_reset();
      send_word(32'd1025);
      n_cmp++; if ({o_err, o_rx_ready, o_done} !== 3'b100) begin n_bad++; $display("FAIL err_flags: got %b want 100", {o_err, o_rx_ready, o_done}); end
      send_word(32'h11223344);
      repeat (3) @(posedge i_clk); #1;
      n_cmp++; if ({o_err, o_core_rst_n} !== 2'b10) begin n_bad++; $display("FAIL err_core_rst: got %b want 10", {o_err, o_core_rst_n}); end
      n_cmp++; if (wr_addr_q.size() !== 0) begin n_bad++; $display("FAIL err_nwrites: got %0d want 0", wr_addr_q.size()); end
   endtask

   task automatic test_max_len();
      int nbad_words;
      do_reset();
      send_word(32'd1024);
      for (int k = 0; k < 1024; k++) send_word(32'hA500_0000 + 32'(k));
      n_cmp++; if ({o_done, o_err} !== 2'b10) begin n_bad++; $display("FAIL max_done: got %b want 10", {o_done, o_err}); end
      @(posedge i_clk); #1;
      n_cmp++; if (wr_addr_q.size() !== 1024) begin n_bad++; $display("FAIL max_nwrites: got %0d want 1024", wr_addr_q.size()); end
      else begin
         n_cmp++; if ({wr_addr_q[1023], wr_data_q[1023]} !== {10'd1023, 32'hA50003FF}) begin n_bad++; $display("FAIL max_last: got %h/%h want 3ff/a50003ff", wr_addr_q[1023], wr_data_q[1023]); end
         nbad_words = 0;
         for (int k = 0; k < 1024; k++)
            if ({wr_addr_q[k], wr_data_q[k]} !== {10'(k), 32'hA500_0000 + 32'(k)}) nbad_words++;
         n_cmp++; if (nbad_words !== 0) begin n_bad++; $display("FAIL max_all_words: got %0d bad words want 0", nbad_words); end
      end
   endtask

   task automatic test_gaps();
      logic [31:0] img [4];
      img[0] = 32'd3; img[1] = 32'h00100513; img[2] = 32'h00200593; img[3] = 32'hCAFEF00D;
      do_reset();
      for (int w = 0; w < 4; w++) begin
         for (int i = 0; i < 4; i++) begin
            repeat ($urandom_range(0, 2)) begin
               i_rx_data = 8'($urandom);   // junk while valid is low
               @(posedge i_clk); #1;
            end
            send_byte(img[w][8*i +: 8]);
         end
      end
      @(posedge i_clk); #1;
      n_cmp++; if (o_done !== 1'b1) begin n_bad++; $display("FAIL gaps_done: got %b want 1", o_done); end
      n_cmp++; if (wr_addr_q.size() !== 3) begin n_bad++; $display("FAIL gaps_nwrites: got %0d want 3", wr_addr_q.size()); end
      else begin
         for (int k = 0; k < 3; k++) begin
            n_cmp++; if ({wr_addr_q[k], wr_data_q[k]} !== {10'(k), img[k+1]}) begin n_bad++; $display("FAIL gaps_w%0d: got %h/%h want %h/%h", k, wr_addr_q[k], wr_data_q[k], 10'(k), img[k+1]); end
         end
      end
   endtask

   task automatic test_mid_reset();
      do_reset();
      send_word(32'd2);
      send_byte(8'h11);
      send_byte(8'h22);
      i_rst_n = 1'b0;
      #2;
      n_cmp++; if ({o_we_inst, o_done, o_err, o_core_rst_n} !== 4'b0000) begin n_bad++; $display("FAIL midrst_async: got %b want 0000", {o_we_inst, o_done, o_err, o_core_rst_n}); end
      do_reset();
      send_word(32'd1);
      send_word(32'hDEADBEEF);
      @(posedge i_clk); #1;
      n_cmp++; if (wr_addr_q.size() !== 1) begin n_bad++; $display("FAIL midrst_nwrites: got %0d want 1", wr_addr_q.size()); end
      else begin
         n_cmp++; if ({wr_addr_q[0], wr_data_q[0]} !== {10'd0, 32'hDEADBEEF}) begin n_bad++; $display("FAIL midrst_w0: got %h/%h want 000/deadbeef", wr_addr_q[0], wr_data_q[0]); end
      end
      n_cmp++; if ({o_done, o_core_rst_n} !== 2'b11) begin n_bad++; $display("FAIL midrst_done: got %b want 11", {o_done, o_core_rst_n}); end
   endtask

   initial begin
      test_reset();
      test_basic_load();
      test_after_done();
      test_zero_len();
      test_len_error();
      test_max_len();
      test_gaps();
      test_mid_reset();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/inst_loader.md
INST_LOADER -- requirements
Module: inst_loader

Interface
REQ-001 Parameter DATA_WIDTH, default 32, instruction word width in bits; only 32 is supported.
REQ-002 Parameter INST_MEM_ADDR_WIDTH, default 10, word-address width of the instruction memory (depth = 2^INST_MEM_ADDR_WIDTH).
REQ-003 Port i_clk  input  1  single clock for all logic.
REQ-004 Port i_rst_n  input  1  asynchronous, active-low reset.
REQ-005 Port i_rx_valid  input  1  byte available from upstream UART receiver.
REQ-006 Port i_rx_data  input  8  received byte.
REQ-007 Port o_rx_ready  output  1  loader can accept a byte this cycle.
REQ-008 Port o_we_inst  output  1  instruction memory write strobe, one-cycle pulse.
REQ-009 Port o_addr_inst  output  INST_MEM_ADDR_WIDTH  instruction memory word address.
REQ-010 Port o_wrdata_inst  output  DATA_WIDTH  instruction word to write.
REQ-011 Port o_core_rst_n  output  1  active-low reset to riscv_core; held low until the load completes.
REQ-012 Port o_done  output  1  load completed successfully.
REQ-013 Port o_err  output  1  length header exceeds memory depth.

Function
REQ-014 A byte SHALL be accepted only in a cycle where i_rx_valid and o_rx_ready are both high; no other cycle SHALL change assembly state.
REQ-015 FSM states: S_LEN, S_DATA, S_DONE, S_ERR; the reset state SHALL be S_LEN.
REQ-016 o_rx_ready SHALL be high in S_LEN and S_DATA and low in S_DONE and S_ERR.
REQ-017 S_LEN SHALL collect 4 bytes into a 32-bit word count N, little-endian (first byte = bits 7:0).
REQ-018 On the 4th accepted S_LEN byte: N == 0 -> S_DONE; N > 2^INST_MEM_ADDR_WIDTH -> S_ERR; otherwise -> S_DATA with word index 0.
REQ-019 S_DATA SHALL assemble each group of 4 accepted bytes into one word, little-endian.
REQ-020 In the cycle after the 4th byte of word k is accepted, the block SHALL pulse o_we_inst for one cycle with o_addr_inst = k and o_wrdata_inst = assembled word.
REQ-021 Byte acceptance SHALL continue back-to-back (one byte per cycle) with no stall around the write pulse; word assembly SHALL use a holding register separate from the write-data register.
REQ-022 The word index SHALL increment after each write; after word N-1 is written, the FSM SHALL enter S_DONE in the same cycle as that write pulse.
REQ-023 The byte counter SHALL wrap 3 -> 0 and be cleared on every state change.
REQ-024 o_done SHALL be high exactly while in S_DONE; o_err SHALL be high exactly while in S_ERR.
REQ-025 o_core_rst_n SHALL be a registered copy of (state == S_DONE) and SHALL go high one cycle after o_done rises; it SHALL never be high in S_ERR.
REQ-026 S_DONE and S_ERR SHALL be terminal; only i_rst_n SHALL exit them, and bytes presented there SHALL be ignored.
REQ-027 o_we_inst SHALL be low in every cycle that does not carry a write from REQ-020.

Reset
REQ-028 Asserting i_rst_n low SHALL asynchronously force: state S_LEN, byte counter 0, word index 0, N 0, o_we_inst 0, o_addr_inst 0, o_wrdata_inst 0, o_done 0, o_err 0, o_core_rst_n 0.
REQ-029 Reset in the middle of a load SHALL discard partial bytes and words; the next load SHALL restart at the length header and address 0.
REQ-030 o_rx_ready SHALL be high from the first clock edge after reset deassertion.

Verification
REQ-031 Bytes 02 00 00 00, 13 05 10 00, 93 05 20 00 sent back-to-back -> writes addr0 = 0x00100513, addr1 = 0x00200593; o_done high in the same cycle as the second write; o_core_rst_n high one cycle later.
REQ-032 Header 00 00 00 00 -> S_DONE with no o_we_inst pulse; o_core_rst_n rises one cycle after o_done.
REQ-033 With INST_MEM_ADDR_WIDTH = 10, header 01 04 00 00 (N = 1025) -> o_err = 1, o_rx_ready = 0, o_core_rst_n stays 0, and no writes occur; header 00 04 00 00 (N = 1024) is accepted and the last write goes to addr 1023.
REQ-034 Random i_rx_valid gaps (about 50% duty) during a 3-word load -> write data and addresses identical to the gap-free run; no byte is duplicated or dropped.
REQ-035 Reset asserted after 6 bytes of a load, then a complete 1-word load of DEADBEEF (bytes EF BE AD DE) -> single write addr0 = 0xDEADBEEF; no write from the aborted load.
REQ-036 Extra bytes driven after S_DONE -> o_rx_ready = 0 and no o_we_inst pulse; all outputs stable.
